action_operand_xbar: RTL and testbench
======================================

Name: action_operand_xbar

Overview:
- Operand crossbar directly upstream of the ALU bank in each RMT stage.
- Takes the stage's PHV (NUM_CONT containers) and the VLIW action word (one ACTION_LEN sub-action per ALU).
- Per ALU lane, decodes the opcode, selects operand_1/operand_2 from PHV containers or the immediate, and drives the ALU's action/operand/valid inputs.
- Also delays the original PHV so it arrives at the PHV merge point aligned with the ALU outputs.

Parameters:
- STAGE, 0, stage index; informational only.
- NUM_CONT, 8, number of DATA_WIDTH containers in the PHV.
- NUM_ALU, 8, number of ALU lanes.
- ACTION_LEN, 25, sub-action width per lane.
- DATA_WIDTH, 48, container and operand width.
- ALU_LAT, 2, latency of the downstream ALU in cycles; sets the extra PHV delay.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- phv_in  in  NUM_CONT*DATA_WIDTH  PHV; container k at bits [k*DW +: DW].
- phv_valid_in  in  1  PHV valid.
- vliw_in  in  NUM_ALU*ACTION_LEN  actions; lane j at bits [j*ACTION_LEN +: ACTION_LEN].
- vliw_valid_in  in  1  action valid; must coincide with phv_valid_in.
- action_out  out  NUM_ALU*ACTION_LEN  registered copy of each lane's action.
- action_valid_out  out  NUM_ALU  per-lane valid to ALU.
- operand_1_out  out  NUM_ALU*DATA_WIDTH  per-lane operand 1.
- operand_2_out  out  NUM_ALU*DATA_WIDTH  per-lane operand 2.
- phv_out  out  NUM_CONT*DATA_WIDTH  PHV delayed by 2+ALU_LAT cycles.
- phv_valid_out  out  1  valid for phv_out.
- bad_idx_cnt  out  16  saturating count of out-of-range container indices.
- bad_op_cnt  out  16  saturating count of unsupported opcodes.
- mismatch_cnt  out  16  saturating count of phv_valid_in/vliw_valid_in disagreements.

Behaviour:
- Reset (async, rst_n low): every output register, pipeline register, delay-line entry and counter goes to 0. Asserting reset mid-packet discards all in-flight data with no partial outputs. Outputs stay 0 until the first accepted input after release.
- Accept rule: input accepted only when phv_valid_in & vliw_valid_in.
  - If exactly one valid is high: nothing enters the pipeline and mismatch_cnt increments.
- Stage 1 (cycle +1): register PHV, VLIW and the accept flag.
- Stage 2 (cycle +2): per-lane decode and mux, registered into the *_out ports. Operand latency is exactly 2 cycles. Throughput is 1 input per cycle; there is no backpressure, since the ALUs cannot stall.
- Sub-action fields: opcode [24:21], idx1 [20:16], idx2 [15:11], imm [15:0].
- Opcodes and operand selection:
  - 0001/1001 (add) and 0010/1010 (sub): op1 = C[idx1], op2 = C[idx2].
  - 0011/1011 (addi) and 0100/1100 (subi): op1 = C[idx1], op2 = imm zero-extended to DATA_WIDTH; idx2 is ignored.
  - 0000: nop; lane valid 0, operands 0, no counter change.
  - All other opcodes: lane valid 0, operands 0, bad_op_cnt += 1 per lane.
- Index range: any used idx >= NUM_CONT is invalid. The lane is forced to valid 0 with operands 0, and bad_idx_cnt += 1 per offending lane (a lane with both indices bad counts 1).
- action_out always carries the accepted VLIW, including nop and bad lanes.
- action_valid_out[j] = accepted & opcode supported & indices valid. When nothing is accepted, all lanes are 0 and operands hold 0.
- PHV delay: phv_out/phv_valid_out come from a shift line of depth 2+ALU_LAT, fed with the stage-1 PHV and accept flag. Invalid slots shift zeros.
- Counters:
  - Multiple lanes erring in one cycle add their count in a single update.
  - All counters saturate at 16'hFFFF and never wrap.
  - Counters clear only on reset.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then idle -> all outputs 0, counters 0.
- add: C0=48'h10, C3=48'h5, lane0 = opcode 0001, idx1=0, idx2=3, single-cycle valid at T -> at T+2 action_valid_out[0]=1, op1=0x10, op2=0x5, other lanes 0; phv_valid_out=1 at T+4 with the original PHV.
- addi: lane2 = opcode 0011, idx1=7, imm=16'hBEEF, C7=48'hFFFF_FFFF_FFFF -> op1=48'hFFFF_FFFF_FFFF, op2=48'h0000_0000_BEEF, valid[2]=1.
- Bad index/opcode: lane1 idx1=9, lane4 opcode 0110, same cycle -> valid[1]=valid[4]=0, bad_idx_cnt=1, bad_op_cnt=1.
- Mismatch + back-to-back:
  - phv_valid_in=1 with vliw_valid_in=0 -> mismatch_cnt=1 and no outputs.
  - 4 consecutive valid cycles -> 4 consecutive result cycles with correct ordering and no gaps.
- Saturation/reset mid-flight:
  - Force 70000 bad-index events -> bad_idx_cnt=16'hFFFF.
  - Assert rst_n low at T+1 after an accepted input -> nothing emerges at T+2 or T+4.

Source files
------------

// File: rtl/action_operand_xbar_if.sv
// Bus bundle between the operand crossbar and its neighbours.
//   Request side : phv_in, phv_valid_in, vliw_in, vliw_valid_in
//   ALU side     : action_out, action_valid_out, operand_1_out, operand_2_out
//   PHV bypass   : phv_out, phv_valid_out
//   Status       : bad_idx_cnt, bad_op_cnt, mismatch_cnt
// master = the agent feeding PHV/VLIW and consuming results; slave = the crossbar.
interface action_operand_xbar_if #(
  parameter int NUM_CONT   = 8,
  parameter int NUM_ALU    = 8,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48
);
  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in;
  logic                           phv_valid_in;
  logic [NUM_ALU*ACTION_LEN-1:0]  vliw_in;
  logic                           vliw_valid_in;
  logic [NUM_ALU*ACTION_LEN-1:0]  action_out;
  logic [NUM_ALU-1:0]             action_valid_out;
  logic [NUM_ALU*DATA_WIDTH-1:0]  operand_1_out;
  logic [NUM_ALU*DATA_WIDTH-1:0]  operand_2_out;
  logic [NUM_CONT*DATA_WIDTH-1:0] phv_out;
  logic                           phv_valid_out;
  logic [15:0]                    bad_idx_cnt;
  logic [15:0]                    bad_op_cnt;
  logic [15:0]                    mismatch_cnt;

  modport master (
    output phv_in, phv_valid_in, vliw_in, vliw_valid_in,
    input  action_out, action_valid_out, operand_1_out, operand_2_out,
    input  phv_out, phv_valid_out, bad_idx_cnt, bad_op_cnt, mismatch_cnt
  );

  modport slave (
    input  phv_in, phv_valid_in, vliw_in, vliw_valid_in,
    output action_out, action_valid_out, operand_1_out, operand_2_out,
    output phv_out, phv_valid_out, bad_idx_cnt, bad_op_cnt, mismatch_cnt
  );
endinterface

// File: rtl/action_operand_xbar.sv
// Operand crossbar in front of an RMT stage's ALU bank.
// Per ALU lane it decodes the sub-action, picks operand_1/operand_2 from PHV
// containers or the immediate, and drives the lane's action/operand/valid.
// The original PHV is delayed so it meets the ALU results at the merge point.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset; clears every register
//   bus    - action_operand_xbar_if.slave (inputs, ALU-side outputs, delayed
//            PHV, saturating error counters)
// Latency: operands 2 cycles, phv_out 2+ALU_LAT cycles. No backpressure.
module action_operand_xbar #(
  parameter int STAGE      = 0,
  parameter int NUM_CONT   = 8,
  parameter int NUM_ALU    = 8,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int ALU_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  action_operand_xbar_if.slave  bus
);

  localparam int PHV_W  = NUM_CONT * DATA_WIDTH;
  localparam int VLIW_W = NUM_ALU * ACTION_LEN;
  // Stage 1 already supplies one cycle of PHV delay, so the line adds 1+ALU_LAT.
  // STAGE is informational only; it is folded in with zero weight.
  localparam int DLY    = 1 + ALU_LAT + (STAGE * 0);
  localparam int SUM_W  = $clog2(NUM_ALU + 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                          input logic [SUM_W-1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(inc);
    return (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[15:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [PHV_W-1:0] phv,
                                                 input logic [4:0] idx);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CONT; k++) begin
      if (idx == 5'(k)) r = phv[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  logic [PHV_W-1:0]            phv_p1;
  logic [VLIW_W-1:0]           vliw_p1;
  logic                        vld_p1;
  logic                        mis_p1;

  logic [VLIW_W-1:0]           act_p2;
  logic [NUM_ALU-1:0]          vld_p2;
  logic [NUM_ALU*DATA_WIDTH-1:0] op1_p2;
  logic [NUM_ALU*DATA_WIDTH-1:0] op2_p2;
  logic [15:0]                 bad_idx_cnt_q;
  logic [15:0]                 bad_op_cnt_q;
  logic [15:0]                 mismatch_cnt_q;

  logic [PHV_W-1:0]            dly_phv [DLY];
  logic [DLY-1:0]              dly_vld;

  logic [NUM_ALU-1:0]            lane_vld_d;
  logic [NUM_ALU*DATA_WIDTH-1:0] op1_d;
  logic [NUM_ALU*DATA_WIDTH-1:0] op2_d;
  logic [SUM_W-1:0]              bad_idx_sum;
  logic [SUM_W-1:0]              bad_op_sum;
  logic [ACTION_LEN-1:0]         act;
  logic [3:0]                    opc;
  logic [4:0]                    idx1;
  logic [4:0]                    idx2;
  logic [15:0]                   imm;
  logic                          supported;
  logic                          uses_idx2;
  logic                          idx_bad;

  // ---- stage 1: capture PHV, VLIW and the accept / disagreement flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_p1  <= '0;
      vliw_p1 <= '0;
      vld_p1  <= 1'b0;
      mis_p1  <= 1'b0;
    end else begin
      phv_p1  <= bus.phv_in;
      vliw_p1 <= bus.vliw_in;
      vld_p1  <= bus.phv_valid_in & bus.vliw_valid_in;
      mis_p1  <= bus.phv_valid_in ^ bus.vliw_valid_in;
    end
  end

  // ---- stage 2 decode: per-lane opcode check, index check, operand mux ----
  always_comb begin
    lane_vld_d  = '0;
    op1_d       = '0;
    op2_d       = '0;
    bad_idx_sum = '0;
    bad_op_sum  = '0;
    act         = '0;
    opc         = '0;
    idx1        = '0;
    idx2        = '0;
    imm         = '0;
    supported   = 1'b0;
    uses_idx2   = 1'b0;
    idx_bad     = 1'b0;
    for (int j = 0; j < NUM_ALU; j++) begin
      act  = vliw_p1[j*ACTION_LEN +: ACTION_LEN];
      opc  = act[24:21];
      idx1 = act[20:16];
      idx2 = act[15:11];
      imm  = act[15:0];
      // Bit 3 of the opcode is a don't-care for operand selection.
      supported = (opc[2:0] >= 3'd1) && (opc[2:0] <= 3'd4);
      uses_idx2 = (opc[2:0] <= 3'd2);
      idx_bad   = (int'(idx1) >= NUM_CONT) ||
                  (uses_idx2 && (int'(idx2) >= NUM_CONT));
      if (vld_p1 && supported) begin
        if (idx_bad) begin
          bad_idx_sum = bad_idx_sum + SUM_W'(1);
        end else begin
          lane_vld_d[j] = 1'b1;
          op1_d[j*DATA_WIDTH +: DATA_WIDTH] = pick(phv_p1, idx1);
          op2_d[j*DATA_WIDTH +: DATA_WIDTH] =
            uses_idx2 ? pick(phv_p1, idx2) : DATA_WIDTH'(imm);
        end
      end else if (vld_p1 && (opc != 4'd0)) begin
        bad_op_sum = bad_op_sum + SUM_W'(1);
      end
    end
  end

  // ---- stage 2 register: ALU-facing outputs and error counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_p2         <= '0;
      vld_p2         <= '0;
      op1_p2         <= '0;
      op2_p2         <= '0;
      bad_idx_cnt_q  <= '0;
      bad_op_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
    end else begin
      act_p2         <= vld_p1 ? vliw_p1 : '0;
      vld_p2         <= lane_vld_d;
      op1_p2         <= op1_d;
      op2_p2         <= op2_d;
      bad_idx_cnt_q  <= sat_add(bad_idx_cnt_q, bad_idx_sum);
      bad_op_cnt_q   <= sat_add(bad_op_cnt_q, bad_op_sum);
      mismatch_cnt_q <= sat_add(mismatch_cnt_q, SUM_W'(mis_p1));
    end
  end

  // ---- PHV delay line: rejected slots carry zeros ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) dly_phv[i] <= '0;
      dly_vld <= '0;
    end else begin
      dly_phv[0] <= vld_p1 ? phv_p1 : '0;
      dly_vld[0] <= vld_p1;
      for (int i = 1; i < DLY; i++) begin
        dly_phv[i] <= dly_phv[i-1];
        dly_vld[i] <= dly_vld[i-1];
      end
    end
  end

  assign bus.action_out       = act_p2;
  assign bus.action_valid_out = vld_p2;
  assign bus.operand_1_out    = op1_p2;
  assign bus.operand_2_out    = op2_p2;
  assign bus.phv_out          = dly_phv[DLY-1];
  assign bus.phv_valid_out    = dly_vld[DLY-1];
  assign bus.bad_idx_cnt      = bad_idx_cnt_q;
  assign bus.bad_op_cnt       = bad_op_cnt_q;
  assign bus.mismatch_cnt     = mismatch_cnt_q;

endmodule

// File: tb/tb_action_operand_xbar.sv
// Self-checking bench for action_operand_xbar: directed steps plus random
// traffic, compared every cycle against a behavioural model of the crossbar.
module tb_action_operand_xbar;
  localparam int NC  = 8;
  localparam int NA  = 8;
  localparam int AL  = 25;
  localparam int DW  = 48;
  localparam int LAT = 2;
  localparam int PW  = NC * DW;
  localparam int VW  = NA * AL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  action_operand_xbar_if #(.NUM_CONT(NC), .NUM_ALU(NA), .ACTION_LEN(AL),
                           .DATA_WIDTH(DW)) bus ();

  action_operand_xbar #(.STAGE(0), .NUM_CONT(NC), .NUM_ALU(NA),
                        .ACTION_LEN(AL), .DATA_WIDTH(DW), .ALU_LAT(LAT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [VW-1:0]    act;
    logic [NA-1:0]    vld;
    logic [NA*DW-1:0] op1;
    logic [NA*DW-1:0] op2;
    logic [PW-1:0]    phv;
    logic             pvld;
    logic [15:0]      cbi;
    logic [15:0]      cbo;
    logic [15:0]      cmm;
  } exp_t;

  exp_t ring [8];
  int   cyc = 8;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_bi = 0, m_bo = 0, m_mm = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [AL-1:0] lane(input int op, input int i1, input int lo16);
    logic [AL-1:0] a;
    a = {4'(op), 5'(i1), 16'(lo16)};
    return a;
  endfunction

  // Reference: what the ALU side should see for one input beat.
  function automatic exp_t model(input logic [PW-1:0] phv, input logic pv,
                                 input logic [VW-1:0] vliw, input logic vv,
                                 output int nbi, output int nbo);
    exp_t e;
    logic [AL-1:0] a;
    int op, i1, i2, imm;
    e = '0;
    nbi = 0;
    nbo = 0;
    if (pv && vv) begin
      e.act  = vliw;
      e.phv  = phv;
      e.pvld = 1'b1;
      for (int j = 0; j < NA; j++) begin
        a   = vliw[j*AL +: AL];
        op  = int'(a[24:21]);
        i1  = int'(a[20:16]);
        i2  = int'(a[15:11]);
        imm = int'(a[15:0]);
        if (op inside {1, 2, 9, 10}) begin
          if (i1 >= NC || i2 >= NC) nbi++;
          else begin
            e.vld[j] = 1'b1;
            e.op1[j*DW +: DW] = phv[i1*DW +: DW];
            e.op2[j*DW +: DW] = phv[i2*DW +: DW];
          end
        end else if (op inside {3, 4, 11, 12}) begin
          if (i1 >= NC) nbi++;
          else begin
            e.vld[j] = 1'b1;
            e.op1[j*DW +: DW] = phv[i1*DW +: DW];
            e.op2[j*DW +: DW] = DW'(imm);
          end
        end else if (op != 0) begin
          nbo++;
        end
      end
    end
    return e;
  endfunction

  task automatic tick();
    exp_t a, p;
    @(posedge clk);
    #1;
    cyc++;
    a = ring[(cyc - 2) % 8];
    p = ring[(cyc - 4) % 8];
    chk("action_out",       512'(bus.action_out),       512'(a.act));
    chk("action_valid_out", 512'(bus.action_valid_out), 512'(a.vld));
    chk("operand_1_out",    512'(bus.operand_1_out),    512'(a.op1));
    chk("operand_2_out",    512'(bus.operand_2_out),    512'(a.op2));
    chk("bad_idx_cnt",      512'(bus.bad_idx_cnt),      512'(a.cbi));
    chk("bad_op_cnt",       512'(bus.bad_op_cnt),       512'(a.cbo));
    chk("mismatch_cnt",     512'(bus.mismatch_cnt),     512'(a.cmm));
    chk("phv_out",          512'(bus.phv_out),          512'(p.phv));
    chk("phv_valid_out",    512'(bus.phv_valid_out),    512'(p.pvld));
  endtask

  task automatic step(input logic [PW-1:0] phv, input logic pv,
                      input logic [VW-1:0] vliw, input logic vv);
    exp_t e;
    int nbi, nbo;
    bus.phv_in        = phv;
    bus.phv_valid_in  = pv;
    bus.vliw_in       = vliw;
    bus.vliw_valid_in = vv;
    e = model(phv, pv, vliw, vv, nbi, nbo);
    if (rst_n) begin
      m_bi = sat(m_bi + nbi);
      m_bo = sat(m_bo + nbo);
      if (pv != vv) m_mm = sat(m_mm + 1);
      e.cbi = 16'(m_bi);
      e.cbo = 16'(m_bo);
      e.cmm = 16'(m_mm);
    end else begin
      e = '0;
    end
    ring[cyc % 8] = e;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ring[i] = '0;
    m_bi = 0;
    m_bo = 0;
    m_mm = 0;
  endtask

  function automatic logic [PW-1:0] rand_phv();
    logic [PW-1:0] p;
    for (int b = 0; b < PW; b++) p[b] = 1'($urandom);
    return p;
  endfunction

  function automatic logic [VW-1:0] rand_vliw();
    logic [VW-1:0] v;
    for (int j = 0; j < NA; j++)
      v[j*AL +: AL] = lane(int'($urandom_range(0, 15)), int'($urandom_range(0, 9)),
                           int'({5'($urandom_range(0, 9)), 11'($urandom)}));
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] phv;
    logic [VW-1:0] vliw;
    logic          pv, vv;

    bus.phv_in = '0;
    bus.phv_valid_in = 1'b0;
    bus.vliw_in = '0;
    bus.vliw_valid_in = 1'b0;
    clear_model();

    // Reset held for three cycles, then idle.
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(4);

    // add: lane0 = C0 + C3.
    phv = rand_phv();
    phv[0*DW +: DW] = 48'h10;
    phv[3*DW +: DW] = 48'h5;
    vliw = '0;
    vliw[0*AL +: AL] = lane(1, 0, 3 << 11);
    step(phv, 1'b1, vliw, 1'b1);
    idle(4);

    // addi: lane2 = C7 + 0xBEEF.
    phv = rand_phv();
    phv[7*DW +: DW] = 48'hFFFF_FFFF_FFFF;
    vliw = '0;
    vliw[2*AL +: AL] = lane(3, 7, 16'hBEEF);
    step(phv, 1'b1, vliw, 1'b1);
    idle(4);

    // Bad index on lane1, bad opcode on lane4, in the same beat.
    phv = rand_phv();
    vliw = '0;
    vliw[1*AL +: AL] = lane(1, 9, 2 << 11);
    vliw[4*AL +: AL] = lane(6, 0, 0);
    step(phv, 1'b1, vliw, 1'b1);
    idle(4);

    // PHV valid without VLIW valid.
    step(rand_phv(), 1'b1, rand_vliw(), 1'b0);
    idle(4);

    // Four back-to-back accepted beats.
    for (int i = 0; i < 4; i++) step(rand_phv(), 1'b1, rand_vliw(), 1'b1);
    idle(5);

    // Random traffic including valid disagreements.
    for (int i = 0; i < 300; i++) begin
      pv = ($urandom_range(0, 3) != 0);
      vv = ($urandom_range(0, 7) == 0) ? !pv : pv;
      step(rand_phv(), pv, rand_vliw(), vv);
    end
    idle(5);

    // Reset one cycle after an accepted beat: nothing may emerge.
    phv = rand_phv();
    vliw = '0;
    vliw[0*AL +: AL] = lane(1, 1, 2 << 11);
    step(phv, 1'b1, vliw, 1'b1);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_reset_valid", 512'(bus.action_valid_out), 512'(0));
    idle(1);
    rst_n = 1'b1;
    idle(5);

    // Saturation: 8 bad-index lanes per beat, 8750 beats = 70000 events.
    vliw = '0;
    for (int j = 0; j < NA; j++) vliw[j*AL +: AL] = lane(1, 31, 0);
    for (int i = 0; i < 8750; i++) step(phv, 1'b1, vliw, 1'b1);
    idle(4);
    chk("bad_idx_saturated", 512'(bus.bad_idx_cnt), 512'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
